// File: rtl/neuron_feeder.sv
// ---------------------------------------------------------------------------
// neuron_feeder
//
// Captures one image of NUM_INPUTS pixels into an internal buffer, then
// streams it NUM_NEURONS times into a single time-shared neuron MAC stage.
// Each pass fetches its weights and bias from external synchronous ROMs
// (1-cycle read latency). Before starting the next pass, the feeder waits
// for the neuron's completion pulse.
//
// Optional feature macro: FEEDER_STALL_EN adds the `stall` input, which
// holds issue in RUN while asserted.
//
// Ports
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   pix_in       : image pixel, accepted when pix_valid && pix_ready
//   pix_valid    : pix_in is valid
//   pix_ready    : feeder accepts a pixel this cycle (LOAD state)
//   w_addr       : weight ROM address; w_data is returned one cycle later
//   w_data       : weight ROM read data
//   b_addr       : bias ROM address (current neuron index)
//   b_data       : bias ROM read data, one cycle after b_addr
//   data_out     : pixel to neuron data_in
//   weight_out   : weight to neuron weight_in
//   bias_out     : bias to neuron bias_in, stable for the whole pass
//   beat_valid   : neuron input_valid
//   nrn_done     : neuron out_valid pulse, ends the current pass
//   neuron_idx   : index of the current pass
//   busy         : high from first accepted pixel until the last pass ends
//   img_done     : one-cycle pulse after the last pass completes
//   stall        : (FEEDER_STALL_EN only) hold issue while high
// ---------------------------------------------------------------------------
module neuron_feeder #(
    parameter int IN_WIDTH    = 16,
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 10,
    parameter int PIX_AW      = $clog2(NUM_INPUTS),
    parameter int W_AW        = $clog2(NUM_INPUTS*NUM_NEURONS),
    parameter int N_AW        = $clog2(NUM_NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] pix_in,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [W_AW-1:0]     w_addr,
    input  logic [IN_WIDTH-1:0] w_data,
    output logic [N_AW-1:0]     b_addr,
    input  logic [IN_WIDTH-1:0] b_data,
    output logic [IN_WIDTH-1:0] data_out,
    output logic [IN_WIDTH-1:0] weight_out,
    output logic [IN_WIDTH-1:0] bias_out,
    output logic                beat_valid,
    input  logic                nrn_done,
    output logic [N_AW-1:0]     neuron_idx,
    output logic                busy,
    output logic                img_done
`ifdef FEEDER_STALL_EN
    ,
    input  logic                stall
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_FINISH
    } state_t;

    localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(NUM_INPUTS - 1);
    localparam logic [N_AW-1:0]   LAST_NRN = N_AW'(NUM_NEURONS - 1);

    state_t                state;
    state_t                next_state;
    logic [PIX_AW-1:0]     wr_ptr;
    logic [PIX_AW-1:0]     rd_ptr;
    logic                  hold;
    logic                  issue;
    logic                  load_last;
    logic                  run_last;
    logic                  first_q;
    logic [IN_WIDTH-1:0]   bias_q;
    logic [IN_WIDTH-1:0]   pix_mem [NUM_INPUTS];

`ifdef FEEDER_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign load_last = (state == ST_LOAD) && pix_valid && (wr_ptr == LAST_PIX);
    assign run_last  = issue && (rd_ptr == LAST_PIX);

    // ROM addresses are combinational from the pointers, so the ROM sees the
    // address in the issue cycle and its data lines up with the registered beat.
    assign w_addr = W_AW'(neuron_idx) * W_AW'(NUM_INPUTS) + W_AW'(rd_ptr);
    assign b_addr = neuron_idx;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        pix_ready  = 1'b0;
        img_done   = 1'b0;
        issue      = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_LOAD: begin
                pix_ready = 1'b1;
                busy      = (wr_ptr != '0);
                if (load_last) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                issue = !hold;
                if (run_last) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (nrn_done) begin
                    next_state = (neuron_idx == LAST_NRN) ? ST_FINISH : ST_RUN;
                end
            end
            ST_FINISH: begin
                img_done   = 1'b1;
                next_state = ST_LOAD;
            end
            default: next_state = ST_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers and neuron index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            neuron_idx <= '0;
        end else begin
            if ((state == ST_LOAD) && pix_valid) begin
                wr_ptr <= load_last ? '0 : wr_ptr + PIX_AW'(1);
            end
            if (load_last) begin
                neuron_idx <= '0;
            end else if ((state == ST_WAIT) && nrn_done && (neuron_idx != LAST_NRN)) begin
                neuron_idx <= neuron_idx + N_AW'(1);
            end
            if (issue) begin
                rd_ptr <= run_last ? '0 : rd_ptr + PIX_AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Image buffer write port
    // ------------------------------------------------------------------
    // NOTE: the buffer has no reset; every location is written before it is
    // read, and a reset port would keep it from mapping onto block RAM.
    always_ff @(posedge clk) begin
        if ((state == ST_LOAD) && pix_valid) begin
            pix_mem[wr_ptr] <= pix_in;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: one register stage behind the issue cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_valid <= 1'b0;
            first_q    <= 1'b0;
            data_out   <= '0;
            bias_q     <= '0;
        end else begin
            beat_valid <= issue;
            first_q    <= issue && (rd_ptr == '0);
            if (issue) begin
                data_out <= pix_mem[rd_ptr];
            end
            if (beat_valid && first_q) begin
                bias_q <= b_data;
            end
        end
    end

    // The ROM output register is the beat-aligned stage for weights. The bias
    // is taken straight from the ROM on the first beat and from the captured
    // copy afterwards, so it is valid from the first beat and then holds even
    // though b_addr moves on in WAIT.
    assign weight_out = beat_valid ? w_data : '0;
    assign bias_out   = first_q ? b_data : bias_q;

endmodule

// File: tb/tb_neuron_feeder.sv
module tb_neuron_feeder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Small instance: NUM_INPUTS=4, NUM_NEURONS=2
    logic [15:0] pix_in, w_data, b_data, data_out, weight_out, bias_out;
    logic        pix_valid, pix_ready, beat_valid, nrn_done, busy, img_done, stall;
    logic [2:0]  w_addr;
    logic [0:0]  b_addr, neuron_idx;

    neuron_feeder #(.IN_WIDTH(16), .NUM_INPUTS(4), .NUM_NEURONS(2)) u_dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data), .data_out(data_out),
        .weight_out(weight_out), .bias_out(bias_out), .beat_valid(beat_valid),
        .nrn_done(nrn_done), .neuron_idx(neuron_idx), .busy(busy),
        .img_done(img_done)
`ifdef FEEDER_STALL_EN
        , .stall(stall)
`endif
    );

    // Synchronous ROMs: weight i = 0x1000+i, bias j = 0x2000+j
    always @(posedge clk) begin
        w_data <= 16'h1000 + 16'(w_addr);
        b_data <= 16'h2000 + 16'(b_addr);
    end

    // Full-size instance with default parameters
    logic [15:0] bg_pix_in, bg_w_data, bg_b_data, bg_data_out, bg_weight_out, bg_bias_out;
    logic        bg_pix_valid, bg_pix_ready, bg_beat_valid, bg_nrn_done, bg_busy, bg_img_done;
    logic [12:0] bg_w_addr;
    logic [3:0]  bg_b_addr, bg_neuron_idx;
    logic        bg_stall;

    neuron_feeder u_big (
        .clk(clk), .rst(rst), .pix_in(bg_pix_in), .pix_valid(bg_pix_valid),
        .pix_ready(bg_pix_ready), .w_addr(bg_w_addr), .w_data(bg_w_data),
        .b_addr(bg_b_addr), .b_data(bg_b_data), .data_out(bg_data_out),
        .weight_out(bg_weight_out), .bias_out(bg_bias_out), .beat_valid(bg_beat_valid),
        .nrn_done(bg_nrn_done), .neuron_idx(bg_neuron_idx), .busy(bg_busy),
        .img_done(bg_img_done)
`ifdef FEEDER_STALL_EN
        , .stall(bg_stall)
`endif
    );

    // Big ROMs return their own address, so weight = p*784+n, bias = p
    always @(posedge clk) begin
        bg_w_data <= 16'(bg_w_addr);
        bg_b_data <= 16'(bg_b_addr);
    end

    int bg_max_w   = 0;
    int bg_img_cnt = 0;
    always @(negedge clk) begin
        if (!rst && int'(bg_w_addr) > bg_max_w) bg_max_w = int'(bg_w_addr);
        if (bg_img_done) bg_img_cnt = bg_img_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One cycle per record: inputs driven this cycle, outputs observed this cycle
    typedef struct {
        logic        pv;
        logic [15:0] pix;
        logic        done;
        logic        e_ready;
        logic        e_beat;
        logic [15:0] e_data;
        logic [15:0] e_weight;
        logic [15:0] e_bias;
        logic        e_img;
        logic        e_idx;
        logic        e_busy;
    } vec_t;

    vec_t vecs [18];

    // Collect one pass of 4 beats; optionally stall 3 cycles once nb beats seen
    task automatic run_pass(input int p, input logic [15:0] base, input int stall_after);
        int nb = 0;
        int lat = -1;
        int stall_left = 0;
        bit stalled = 1'b0;
        for (int cyc = 1; cyc <= 30 && nb < 4; cyc++) begin
            @(negedge clk);
            nrn_done  = 1'b0;
            pix_valid = 1'b0;
            if (beat_valid) begin
                if (nb == 0) lat = cyc;
                check($sformatf("p%0d beat%0d data", p, nb), 32'(data_out), 32'(base + 16'(nb)));
                check($sformatf("p%0d beat%0d weight", p, nb), 32'(weight_out),
                      32'(16'h1000 + 16'(p * 4 + nb)));
                check($sformatf("p%0d beat%0d bias", p, nb), 32'(bias_out), 32'(16'h2000 + 16'(p)));
                check($sformatf("p%0d beat%0d idx", p, nb), 32'(neuron_idx), 32'(p));
                nb++;
            end
            if (stall_after >= 0 && !stalled && nb == stall_after) begin
                stall_left = 3;
                stalled    = 1'b1;
            end
            stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
        end
        stall = 1'b0;
        check($sformatf("p%0d beat count", p), 32'(nb), 4);
        check($sformatf("p%0d first beat latency", p), 32'(lat), 2);
        repeat (3) begin
            @(negedge clk);
            check($sformatf("p%0d no extra beat", p), 32'(beat_valid), 0);
        end
    endtask

    task automatic run_image(input logic [15:0] base, input int stall_after);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_in    = base + 16'(k);
        end
        run_pass(0, base, stall_after);
        nrn_done = 1'b1;
        run_pass(1, base, stall_after);
        nrn_done = 1'b1;
        @(negedge clk);
        nrn_done = 1'b0;
        check("img_done after last done", 32'(img_done), 1);
        check("busy in finish", 32'(busy), 0);
        @(negedge clk);
        check("img_done one cycle", 32'(img_done), 0);
        check("pix_ready after finish", 32'(pix_ready), 1);
    endtask

    task automatic run_big();
        int nb;
        int bad;
        for (int i = 0; i < 784; i++) begin
            @(negedge clk);
            bg_pix_valid = 1'b1;
            bg_pix_in    = 16'(i);
        end
        for (int p = 0; p < 10; p++) begin
            nb  = 0;
            bad = 0;
            for (int cyc = 0; cyc < 1000 && nb < 784; cyc++) begin
                @(negedge clk);
                bg_nrn_done  = 1'b0;
                bg_pix_valid = 1'b0;
                if (bg_beat_valid) begin
                    if (bg_data_out !== 16'(nb) || bg_weight_out !== 16'(p * 784 + nb) ||
                        bg_bias_out !== 16'(p) || bg_neuron_idx !== 4'(p))
                        bad++;
                    nb++;
                end
            end
            check($sformatf("big p%0d beat count", p), 32'(nb), 784);
            check($sformatf("big p%0d beat errors", p), 32'(bad), 0);
            @(negedge clk);
            bg_nrn_done = 1'b1;
        end
        @(negedge clk);
        bg_nrn_done = 1'b0;
        check("big img_done", 32'(bg_img_done), 1);
        @(negedge clk);
        check("big img_done count", 32'(bg_img_cnt), 1);
        check("big max w_addr", 32'(bg_max_w), 7839);
        check("big pix_ready end", 32'(bg_pix_ready), 1);
        check("big busy end", 32'(bg_busy), 0);
    endtask

    initial begin
        int nb;
        rst = 1'b1;
        pix_valid = 1'b0; pix_in = '0; nrn_done = 1'b0; stall = 1'b0;
        bg_pix_valid = 1'b0; bg_pix_in = '0; bg_nrn_done = 1'b0; bg_stall = 1'b0;

        //          pv    pix       done  rdy  beat data      weight    bias      img  idx  busy
        vecs[0]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h1000, 16'h2000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h1001, 16'h2000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h1002, 16'h2000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h1003, 16'h2000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2000, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h1004, 16'h2001, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h1005, 16'h2001, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h1006, 16'h2001, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h1007, 16'h2001, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2001, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2001, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h2001, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("rst pix_ready", 32'(pix_ready), 1);
        check("rst beat_valid", 32'(beat_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst img_done", 32'(img_done), 0);
        check("rst neuron_idx", 32'(neuron_idx), 0);
        check("rst data_out", 32'(data_out), 0);
        check("rst weight_out", 32'(weight_out), 0);
        check("rst bias_out", 32'(bias_out), 0);
        check("rst w_addr", 32'(w_addr), 0);
        check("rst b_addr", 32'(b_addr), 0);
        check("rst big pix_ready", 32'(bg_pix_ready), 1);
        check("rst big beat_valid", 32'(bg_beat_valid), 0);
        rst = 1'b0;

        // Basic flow with pix_valid held high throughout and a spurious
        // nrn_done in RUN (cycle 6)
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d pix_ready", i), 32'(pix_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d beat_valid", i), 32'(beat_valid), 32'(vecs[i].e_beat));
            check($sformatf("vec%0d bias_out", i), 32'(bias_out), 32'(vecs[i].e_bias));
            check($sformatf("vec%0d img_done", i), 32'(img_done), 32'(vecs[i].e_img));
            check($sformatf("vec%0d neuron_idx", i), 32'(neuron_idx), 32'(vecs[i].e_idx));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            if (vecs[i].e_beat) begin
                check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].e_data));
                check($sformatf("vec%0d weight_out", i), 32'(weight_out), 32'(vecs[i].e_weight));
            end
            pix_valid = vecs[i].pv;
            pix_in    = vecs[i].pix;
            nrn_done  = vecs[i].done;
        end

        // Finish the second image (0x11 already taken), reset on its 2nd beat
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_in    = 16'h0011 + 16'(k);
        end
        nb = 0;
        for (int cyc = 0; cyc < 20 && nb < 2; cyc++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            if (beat_valid) nb++;
        end
        check("reload beats before reset", 32'(nb), 2);
        check("reload 2nd beat data", 32'(data_out), 32'(16'h0012));
        rst = 1'b1;
        #1;
        check("async rst beat_valid", 32'(beat_valid), 0);
        check("async rst busy", 32'(busy), 0);
        check("async rst pix_ready", 32'(pix_ready), 1);
        check("async rst neuron_idx", 32'(neuron_idx), 0);
        @(negedge clk);
        rst = 1'b0;

        run_image(16'h0021, -1);
`ifdef FEEDER_STALL_EN
        run_image(16'h0031, 2);
`endif

        run_big();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neuron_feeder.md
# neuron_feeder

Sequencer that sits directly upstream of the `neuron` MAC stage and drives its `data_in`/`weight_in`/`bias_in`/`input_valid` inputs. It captures one image of `NUM_INPUTS` pixels into an internal buffer. It then streams that image `NUM_NEURONS` times, once per output neuron, into a single time-shared neuron, fetching each weight and bias from external synchronous ROMs. After each pass it waits for the neuron's completion pulse before starting the next pass.

## Interface
Parameters:
- `IN_WIDTH`, 16: width of pixels, weights and bias (signed Q1.15).
- `NUM_INPUTS`, 784: pixels per image, which is also the beat count per neuron pass.
- `NUM_NEURONS`, 10: passes per image.
- `PIX_AW`, `$clog2(NUM_INPUTS)`: pixel buffer address width.
- `W_AW`, `$clog2(NUM_INPUTS*NUM_NEURONS)`: weight ROM address width.
- `N_AW`, `$clog2(NUM_NEURONS)`: neuron index / bias ROM address width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `pix_in`, in, IN_WIDTH: image pixel.
- `pix_valid`, in, 1: `pix_in` is valid.
- `pix_ready`, out, 1: the feeder accepts a pixel this cycle.
- `w_addr`, out, W_AW: weight ROM address. Data returns on `w_data` one cycle later.
- `w_data`, in, IN_WIDTH: weight ROM read data.
- `b_addr`, out, N_AW: bias ROM address (the neuron index). Data returns on `b_data` one cycle later.
- `b_data`, in, IN_WIDTH: bias ROM read data.
- `data_out`, out, IN_WIDTH: pixel to the neuron's `data_in`.
- `weight_out`, out, IN_WIDTH: weight to the neuron's `weight_in`.
- `bias_out`, out, IN_WIDTH: bias to the neuron's `bias_in`. It is held stable for the whole pass.
- `beat_valid`, out, 1: drives the neuron's `input_valid`.
- `nrn_done`, in, 1: the neuron's `out_valid` pulse.
- `neuron_idx`, out, N_AW: index of the current pass, for the downstream result collector.
- `busy`, out, 1: high from the first accepted pixel until the end of the last pass.
- `img_done`, out, 1: one-cycle pulse after the completion of the last pass is seen.
- `stall`, in, 1: present only when `FEEDER_STALL_EN` is defined.

## Operation
The FSM has four states: LOAD, RUN, WAIT and FINISH. Reset state is LOAD.
- **LOAD:**
  - `pix_ready` is 1.
  - Each cycle with `pix_valid` high, the pixel is written at `wr_ptr` and `wr_ptr` increments.
  - On the write with `wr_ptr == NUM_INPUTS-1`, the FSM goes to RUN. At the same time `wr_ptr` is cleared and `neuron_idx` is set to 0.
- **RUN:**
  - `pix_ready` is 0.
  - Each issue cycle drives:
    - the buffer read address `rd_ptr`;
    - `w_addr = neuron_idx*NUM_INPUTS + rd_ptr`;
    - `b_addr = neuron_idx`.
  - `rd_ptr` increments on every issue cycle.
  - After the issue with `rd_ptr == NUM_INPUTS-1`, no further issues occur and the FSM goes to WAIT. `rd_ptr` is cleared.
- **WAIT:**
  - No issues occur.
  - On `nrn_done`:
    - if `neuron_idx == NUM_NEURONS-1`, go to FINISH;
    - otherwise increment `neuron_idx` and go to RUN.
- **FINISH:**
  - Lasts one cycle, during which `img_done` is 1.
  - The FSM then returns to LOAD.
  - The image buffer contents are retained but will be overwritten by the next image.
- **Arithmetic:** the weight address is computed in W_AW bits with no overflow, by construction of `W_AW`.
- **Spurious completion:** `nrn_done` in LOAD, RUN or FINISH is ignored. No error flag is raised.
- **Pixel backpressure:** `pix_valid` outside LOAD is not accepted, because `pix_ready` is 0.

## Timing
- **Reset values:** every output is 0, and the FSM is in LOAD with all pointers at 0. Because `pix_ready` asserts from LOAD, it is 1 directly after reset.
- **Reset mid-operation:** an asynchronous `rst` during RUN or WAIT aborts immediately. `beat_valid` drops in the same cycle. The partial image is discarded and the next pixel loads at address 0.
- **Read latency:** `beat_valid`, `data_out` and `weight_out` are registered one cycle after their issue cycle. This aligns with the 1-cycle ROM and buffer read latency.
- **Beat count:** each pass produces exactly `NUM_INPUTS` `beat_valid` beats. Without stalls the beats are back-to-back, so a pass takes `NUM_INPUTS` consecutive cycles.
- **Bias timing:** `bias_out` is captured from `b_data` on the first beat of a pass and is stable for the whole pass.
- **Load time:** LOAD takes at least `NUM_INPUTS` cycles.
- **First beat:** the first beat appears 2 cycles after the final pixel handshake (transition into RUN, then read latency).
- **Pass-to-pass gap:** the next pass's first beat follows 2 cycles after `nrn_done`.
- **Image done:** `img_done` rises 1 cycle after the last `nrn_done`.

## Configuration
- **`FEEDER_STALL_EN` defined:**
  - the `stall` input exists;
  - while `stall` is 1 in RUN, no issue occurs and the pointers hold;
  - `beat_valid` is 0 on the cycle after each stalled cycle;
  - data already in the read pipeline still emits exactly once.
- **`FEEDER_STALL_EN` undefined:**
  - the `stall` port is absent;
  - RUN issues every cycle.

## Test plan
- **Basic flow:** with `NUM_INPUTS=4`, `NUM_NEURONS=2`, load pixels 1,2,3,4.
  - Expect beats (1,w[0]),(2,w[1]),(3,w[2]),(4,w[3]) back-to-back with `bias_out=b[0]`.
  - After `nrn_done`, expect beats on w[4..7] with `bias_out=b[1]`.
  - Expect `img_done` 1 cycle after the second `nrn_done`.
- **Load backpressure:** hold `pix_valid` high continuously through the whole run. Expect exactly 4 pixels accepted, then `pix_ready=0` until FINISH, then reload.
- **Spurious completion:** pulse `nrn_done` during RUN. Expect no effect: the beat count stays 4 and `neuron_idx` is unchanged.
- **Async reset:** assert `rst` on the 2nd beat of pass 1. Expect `beat_valid` and `busy` to be 0 immediately and `pix_ready=1`. A fresh image then runs cleanly from neuron 0.
- **Stall (`FEEDER_STALL_EN`):** stall for 3 cycles mid-pass. Expect still exactly 4 beats, in order, with no duplicates.
- **Full size:** default parameters against the neuron model. Expect 10 `nrn_done` pulses, `w_addr` reaching 7839, and `img_done` once.
